// File: rtl/scan_decoder_pkg.sv
// scan_decoder_pkg: shared state type, hold-counter sizing and one-hot helper
package scan_decoder_pkg;
  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
  localparam int MAX_N = 8;
  function automatic int cnt_w(input int hold);
    return hold > 1 ? $clog2(hold) : 1;
  endfunction
  function automatic logic [2**MAX_N-1:0] onehot(input logic [MAX_N-1:0] i);
    return {{(2**MAX_N-1){1'b0}}, 1'b1} << i;
  endfunction
endpackage

// File: rtl/onehot_decoder.sv
// onehot_decoder: combinational N-to-2^N one-hot decode, all-zero when disabled
module onehot_decoder #(
  parameter int N = 3
) (
  input  logic           en,
  input  logic [N-1:0]   idx,
  output logic [2**N-1:0] y
);
  localparam int M = 2**N;
  assign y = en ? M'(1) << idx : '0;
endmodule

// File: rtl/scan_decoder.sv
// scan_decoder: registered one-hot decoder with handshake-loaded direct mode and self-sequencing scan mode
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int N    = 3,
  parameter int HOLD = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           mode,
  input  logic           sel_valid,
  input  logic [N-1:0]   sel,
  output logic           sel_ready,
  output logic [2**N-1:0] y,
  output logic [N-1:0]   idx,
  output logic           wrap
);
  localparam int M  = 2**N;
  localparam int CW = cnt_w(HOLD);
  state_t state, state_n;
  logic [N-1:0] idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [M-1:0] y_n;
  logic wrap_n, acc, last;
  assign sel_ready = ~mode & ~rst;
  assign acc = sel_valid & sel_ready;
  assign last = cnt == CW'(HOLD - 1);
  // a mode change in SCAN takes priority over a same-cycle accept
  always_comb begin
    state_n = state;
    idx_n = idx;
    cnt_n = cnt;
    wrap_n = 1'b0;
    if (!en) idx_n = (acc && state != SCAN) ? sel : idx;
    else if (state == SCAN) begin
      if (!mode) begin
        state_n = DIRECT;
        cnt_n = '0;
      end else begin
        cnt_n = last ? '0 : cnt + 1'b1;
        idx_n = last ? idx + 1'b1 : idx;
        wrap_n = last && &idx;
      end
    end else if (mode) begin
      state_n = SCAN;
      cnt_n = '0;
      idx_n = state == IDLE ? '0 : idx;
    end else if (acc) begin
      state_n = DIRECT;
      idx_n = sel;
    end
  end
  onehot_decoder #(.N(N)) u_dec (.en(en && state_n != IDLE), .idx(idx_n), .y(y_n));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      y <= '0;
      wrap <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      cnt <= cnt_n;
      y <= y_n;
      wrap <= wrap_n;
    end
  end
endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder: directed checks of direct, scan, enable gating and reset behaviour
module tb_scan_decoder;
  logic clk = 0;
  logic rst = 1, en = 1, mode = 0, sel_valid = 0;
  logic [2:0] sel = 0;
  logic sel_ready, wrap;
  logic [7:0] y;
  logic [2:0] idx;
  logic rst2 = 1, en2 = 1, mode2 = 0, sel_valid2 = 0;
  logic [3:0] sel2 = 0;
  logic sel_ready2, wrap2;
  logic [15:0] y2;
  logic [3:0] idx2;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  scan_decoder #(.N(3), .HOLD(4)) dut (.clk(clk), .rst(rst), .en(en), .mode(mode),
    .sel_valid(sel_valid), .sel(sel), .sel_ready(sel_ready), .y(y), .idx(idx), .wrap(wrap));
  scan_decoder #(.N(4), .HOLD(1)) dut2 (.clk(clk), .rst(rst2), .en(en2), .mode(mode2),
    .sel_valid(sel_valid2), .sel(sel2), .sel_ready(sel_ready2), .y(y2), .idx(idx2), .wrap(wrap2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; rst2 = 1; sel_valid = 1; sel = 3;
    #1;
    tests++; if (sel_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b want 0", sel_ready); end
    step();
    tests++; if ({y, idx, wrap} !== 12'h0) begin fails++; $display("FAIL reset_state y=%h idx=%0d wrap=%b want 0", y, idx, wrap); end
    rst = 0; rst2 = 0; sel_valid = 0;
    step();
    tests++; if (y !== 8'h00 || idx !== 3'd0) begin fails++; $display("FAIL idle_zero y=%h idx=%0d want 00/0", y, idx); end
  endtask

  task automatic test_direct();
    sel_valid = 1; sel = 5;
    #1;
    tests++; if (sel_ready !== 1'b1) begin fails++; $display("FAIL direct_ready got %b want 1", sel_ready); end
    step();
    tests++; if (y !== 8'h20 || idx !== 3'd5) begin fails++; $display("FAIL direct_sel5 y=%h idx=%0d want 20/5", y, idx); end
    sel = 1;
    step();
    tests++; if (y !== 8'h02) begin fails++; $display("FAIL b2b_sel1 y=%h want 02", y); end
    sel = 2;
    step();
    tests++; if (y !== 8'h04 || idx !== 3'd2) begin fails++; $display("FAIL b2b_sel2 y=%h idx=%0d want 04/2", y, idx); end
    sel_valid = 0;
  endtask

  task automatic test_scan_idle();
    rst = 1; mode = 1;
    step();
    rst = 0;
    step();
    for (int i = 0; i < 32; i++) begin
      tests++;
      if (y !== (8'h01 << (i / 4)) || wrap !== 1'b0) begin
        fails++; $display("FAIL scan_sweep c%0d y=%h wrap=%b want %h/0", i, y, wrap, 8'h01 << (i / 4));
      end
      step();
    end
    tests++; if (y !== 8'h01 || wrap !== 1'b1) begin fails++; $display("FAIL scan_wrap y=%h wrap=%b want 01/1", y, wrap); end
    step();
    tests++; if (y !== 8'h01 || wrap !== 1'b0) begin fails++; $display("FAIL wrap_pulse y=%h wrap=%b want 01/0", y, wrap); end
    mode = 0;
    step();
  endtask

  task automatic test_direct_to_scan();
    sel_valid = 1; sel = 6;
    step();
    sel_valid = 0; mode = 1;
    tests++; if (y !== 8'h40) begin fails++; $display("FAIL d2s_direct y=%h want 40", y); end
    step();
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (y !== (i < 4 ? 8'h40 : 8'h80) || wrap !== 1'b0) begin
        fails++; $display("FAIL d2s_hold c%0d y=%h wrap=%b want %h/0", i, y, wrap, i < 4 ? 8'h40 : 8'h80);
      end
      step();
    end
    tests++; if (y !== 8'h01 || wrap !== 1'b1) begin fails++; $display("FAIL d2s_wrap y=%h wrap=%b want 01/1", y, wrap); end
  endtask

  task automatic test_en_gap();
    rst = 1;
    step();
    rst = 0;
    step();
    repeat (13) step();
    tests++; if (y !== 8'h08) begin fails++; $display("FAIL gap_pre y=%h want 08", y); end
    en = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      tests++; if (y !== 8'h00 || idx !== 3'd3) begin fails++; $display("FAIL gap_zero c%0d y=%h idx=%0d want 00/3", i, y, idx); end
    end
    en = 1;
    step();
    tests++; if (y !== 8'h08) begin fails++; $display("FAIL gap_resume1 y=%h want 08", y); end
    step();
    tests++; if (y !== 8'h08) begin fails++; $display("FAIL gap_resume2 y=%h want 08", y); end
    step();
    tests++; if (y !== 8'h10 || idx !== 3'd4) begin fails++; $display("FAIL gap_advance y=%h idx=%0d want 10/4", y, idx); end
  endtask

  task automatic test_mode_sel();
    sel_valid = 1; sel = 7;
    #1;
    tests++; if (sel_ready !== 1'b0) begin fails++; $display("FAIL scan_ready got %b want 0", sel_ready); end
    step();
    tests++; if (idx !== 3'd4) begin fails++; $display("FAIL scan_ignore idx=%0d want 4", idx); end
    mode = 0;
    #1;
    tests++; if (sel_ready !== 1'b1) begin fails++; $display("FAIL mode0_ready got %b want 1", sel_ready); end
    step();
    tests++; if (idx !== 3'd4 || y !== 8'h10 || wrap !== 1'b0) begin fails++; $display("FAIL mode_wins idx=%0d y=%h wrap=%b want 4/10/0", idx, y, wrap); end
    step();
    tests++; if (idx !== 3'd7 || y !== 8'h80) begin fails++; $display("FAIL accept_after idx=%0d y=%h want 7/80", idx, y); end
    sel_valid = 0;
  endtask

  task automatic test_en_direct();
    en = 0; sel_valid = 1; sel = 2;
    step();
    sel_valid = 0;
    tests++; if (y !== 8'h00 || idx !== 3'd2) begin fails++; $display("FAIL en0_accept y=%h idx=%0d want 00/2", y, idx); end
    en = 1;
    step();
    tests++; if (y !== 8'h04) begin fails++; $display("FAIL en1_restore y=%h want 04", y); end
  endtask

  task automatic test_reset_mid_scan();
    int n = 0;
    mode = 1;
    step();
    while (idx !== 3'd6 && n < 40) begin step(); n++; end
    tests++; if (idx !== 3'd6 || y !== 8'h40) begin fails++; $display("FAIL reach_idx6 idx=%0d y=%h want 6/40", idx, y); end
    rst = 1;
    step();
    tests++; if ({y, idx, wrap} !== 12'h0) begin fails++; $display("FAIL rst_mid y=%h idx=%0d wrap=%b want 0", y, idx, wrap); end
    rst = 0; mode = 0;
    step();
    tests++; if (y !== 8'h00) begin fails++; $display("FAIL rst_idle y=%h want 00", y); end
  endtask

  task automatic test_n4_hold1();
    mode2 = 1;
    step();
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (y2 !== (16'h0001 << i) || wrap2 !== 1'b0 || idx2 !== 4'(i)) begin
        fails++; $display("FAIL n4_sweep c%0d y=%h idx=%0d wrap=%b want %h/%0d/0", i, y2, idx2, wrap2, 16'h0001 << i, i);
      end
      step();
    end
    tests++; if (y2 !== 16'h0001 || wrap2 !== 1'b1) begin fails++; $display("FAIL n4_wrap y=%h wrap=%b want 0001/1", y2, wrap2); end
    step();
    tests++; if (y2 !== 16'h0002 || wrap2 !== 1'b0) begin fails++; $display("FAIL n4_after y=%h wrap=%b want 0002/0", y2, wrap2); end
    repeat (15) step();
    tests++; if (y2 !== 16'h0001 || wrap2 !== 1'b1) begin fails++; $display("FAIL n4_wrap2 y=%h wrap=%b want 0001/1", y2, wrap2); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_direct();
    test_scan_idle();
    test_direct_to_scan();
    test_en_gap();
    test_mode_sel();
    test_en_direct();
    test_reset_mid_scan();
    test_n4_hold1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
